matrix_fifo_reader: RTL
=======================

MATRIX_FIFO_READER -- requirements
Module: matrix_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width, equal to the prefetch FIFO read width.
REQ-002 SHALL have parameter H_ACTIVE, default 640: pixels per line, legal range 1..4095.
REQ-003 SHALL have parameter V_ACTIVE, default 480: lines per frame, legal range 1..4095.
REQ-004 SHALL have parameter LINE_GAP, default 4: idle cycles inserted after each line, legal range 0..255.
REQ-005 SHALL have port rd_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rd_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that begins one frame.
REQ-008 SHALL have port clear, input, 1 bit: synchronous abort and flush.
REQ-009 SHALL have port fifo_rd_vld, input, 1 bit: prefetch FIFO head is valid.
REQ-010 SHALL have port fifo_rd_data, input, DATA_WIDTH bits: prefetch FIFO head data.
REQ-011 SHALL have port fifo_rd_en, output, 1 bit: pop request to the FIFO.
REQ-012 SHALL have port m_data, output, DATA_WIDTH bits: output pixel.
REQ-013 SHALL have port m_valid, output, 1 bit: output beat valid.
REQ-014 SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-015 SHALL have ports m_sof, m_eol and m_eof, outputs, 1 bit each: first pixel of frame, last pixel of line, last pixel of frame; each is qualified by m_valid.
REQ-016 SHALL have ports busy (output, 1 bit: frame in progress) and frame_done (output, 1 bit: one-cycle pulse).

Function
REQ-017 SHALL use a state machine with states IDLE, RUN, GAP and DONE.
REQ-018 SHALL move from IDLE to RUN on start=1; start SHALL be ignored in all other states.
REQ-019 SHALL drive fifo_rd_en = fifo_rd_vld & (state==RUN) & skid_not_full, combinationally; a pop occurs when fifo_rd_en=1.
REQ-020 SHALL count pops with x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1); x wraps to 0 and y increments on each line-last pop.
REQ-021 SHALL go RUN->GAP on the line-last pop when it is not frame-last and LINE_GAP>0; GAP SHALL hold for exactly LINE_GAP cycles with no pops, then return to RUN.
REQ-022 SHALL stay in RUN on the line-last pop when LINE_GAP=0.
REQ-023 SHALL go RUN->DONE on the frame-last pop (x=H_ACTIVE-1, y=V_ACTIVE-1), then DONE->IDLE after 1 cycle; frame_done=1 in DONE.
REQ-024 SHALL tag each popped beat with sof (x=0,y=0), eol (x=H_ACTIVE-1) and eof (frame-last) and carry the tags with the data.
REQ-025 SHALL buffer beats in a 2-entry skid buffer; a popped beat SHALL appear on m_valid exactly 1 cycle after the pop when the buffer was empty.
REQ-026 SHALL hold m_data, m_valid and the tags stable while m_valid=1 and m_ready=0.
REQ-027 SHALL deassert skid_not_full when both entries are occupied; a pop and an output accept in the same cycle SHALL be legal, with occupancy unchanged.
REQ-028 SHALL keep busy=1 in RUN, GAP and DONE, and additionally while the skid buffer is non-empty.
REQ-029 SHALL, on clear=1, next cycle force IDLE, x=y=0, empty the skid, m_valid=0 and fifo_rd_en=0; clear SHALL take priority over start and pops in the same cycle.
REQ-030 SHALL stall without error when fifo_rd_vld=0 mid-line; counters SHALL hold.

Reset
REQ-031 SHALL, while rd_rst_n=0, asynchronously force state IDLE, x=0, y=0, gap counter 0 and skid empty.
REQ-032 SHALL hold fifo_rd_en, m_valid, m_sof, m_eol, m_eof, busy and frame_done at 0, and m_data at 0, during reset.
REQ-033 SHALL resume operation only in IDLE after reset release; a frame in progress SHALL be discarded.

Structure
REQ-034 SHALL place the state enum type, default parameter values and tag-bit indices in shared package matrix_fifo_pkg.
REQ-035 SHALL implement the 2-entry buffer as sub-module stream_skid_buf (width DATA_WIDTH+3).

Verification (H_ACTIVE=4, V_ACTIVE=2, LINE_GAP=2)
REQ-036 SHALL verify the nominal frame: FIFO preloaded with 8 bytes 0x10..0x17, m_ready=1, start pulse -> outputs 0x10..0x17, sof on 0x10, eol on 0x13 and 0x17, eof on 0x17, exactly 2 pop-free cycles between 0x13 and 0x14, frame_done one cycle, then busy=0.
REQ-037 SHALL verify backpressure: m_ready=0 for 5 cycles after the first beat -> m_data holds 0x10, at most 2 beats are buffered, fifo_rd_en=0 while full, and no data is lost or duplicated.
REQ-038 SHALL verify FIFO underflow: fifo_rd_vld=0 for 3 cycles after 0x11 -> x holds, 0x12 follows with no gap errors and no extra pops.
REQ-039 SHALL verify clear mid-line: clear asserted after 0x12 is popped -> next cycle IDLE, m_valid=0; a new start yields sof on the next FIFO byte.
REQ-040 SHALL verify reset mid-frame: rd_rst_n low during GAP -> all outputs 0 immediately, IDLE after release, and start ignored while busy.

Source files
------------

// File: rtl/matrix_fifo_pkg.sv
// Shared types and constants for the matrix FIFO reader: FSM state encoding,
// default geometry and the bit positions of the per-beat sideband tags.
package matrix_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_LINE_GAP   = 4;

  // Tags ride in the low bits of each buffered beat, data above them.
  localparam int TAG_SOF = 0;
  localparam int TAG_EOL = 1;
  localparam int TAG_EOF = 2;
  localparam int TAG_W   = 3;

  localparam int CNT_W = 12;
  localparam int GAP_W = 8;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry registered skid buffer. Entry 0 is always the output head, so a
// beat written into an empty buffer is presented on the following cycle.
module stream_skid_buf #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] m0_q, m0_d, m1_q, m1_d;
  logic         push, take;

  assign push        = in_valid_i;
  assign take        = out_valid_o & out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_data_o  = m0_q;

  always_comb begin
    cnt_d = cnt_q;
    m0_d  = m0_q;
    m1_d  = m1_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, take})
        2'b10: begin
          if (cnt_q == 2'd0) m0_d = in_data_i;
          else               m1_d = in_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          m0_d  = m1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: new beat lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            m0_d = in_data_i;
          end else begin
            m0_d = m1_q;
            m1_d = in_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 2'd0;
      m0_q  <= '0;
      m1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      m0_q  <= m0_d;
      m1_q  <= m1_d;
    end
  end

endmodule

// File: rtl/matrix_fifo_reader.sv
// Reads one H_ACTIVE x V_ACTIVE frame out of a prefetch FIFO per start pulse,
// inserting LINE_GAP idle cycles between lines and tagging sof/eol/eof.
module matrix_fifo_reader
  import matrix_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int LINE_GAP   = DEF_LINE_GAP
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = DATA_WIDTH + TAG_W;
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LINE_GAP - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               x_last, y_last, pop;
  logic               skid_rdy, skid_vld;
  logic [BW-1:0]      pop_beat, out_beat;

  assign x_last = (x_q == X_LAST);
  assign y_last = (y_q == Y_LAST);

  // clear also blocks the pop so the FIFO head survives for the next frame.
  assign pop        = fifo_rd_vld & (state_q == ST_RUN) & skid_rdy & ~clear;
  assign fifo_rd_en = pop;

  always_comb begin
    pop_beat                = '0;
    pop_beat[BW-1:TAG_W]    = fifo_rd_data;
    pop_beat[TAG_SOF]       = (x_q == '0) & (y_q == '0);
    pop_beat[TAG_EOL]       = x_last;
    pop_beat[TAG_EOF]       = x_last & y_last;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    gap_d   = gap_q;
    if (clear) begin
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (pop) begin
            if (x_last) begin
              x_d = '0;
              if (y_last) begin
                y_d     = '0;
                state_d = ST_DONE;
              end else begin
                y_d = y_q + 1'b1;
                if (LINE_GAP > 0) state_d = ST_GAP;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = ST_RUN;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gap_q   <= gap_d;
    end
  end

  stream_skid_buf #(.W(BW)) u_skid (
    .clk_i       (rd_clk),
    .rst_ni      (rd_rst_n),
    .clear_i     (clear),
    .in_valid_i  (pop),
    .in_data_i   (pop_beat),
    .in_ready_o  (skid_rdy),
    .out_valid_o (skid_vld),
    .out_ready_i (m_ready),
    .out_data_o  (out_beat)
  );

  assign m_valid    = skid_vld;
  assign m_data     = out_beat[BW-1:TAG_W];
  assign m_sof      = skid_vld & out_beat[TAG_SOF];
  assign m_eol      = skid_vld & out_beat[TAG_EOL];
  assign m_eof      = skid_vld & out_beat[TAG_EOF];
  assign busy       = (state_q != ST_IDLE) | skid_vld;
  assign frame_done = (state_q == ST_DONE);

endmodule
